// File: rtl/fpmult_pkg.sv
// Shared constants, FSM state type and exception-vector layout for the
// sequential FP32 mantissa multiplier.
package fpmult_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 48;
    localparam int EXP_W  = 8;
    localparam int EXC_W  = 5;

    // input_exc = {any, ANaN, BNaN, AInf, BInf}
    localparam int EXC_ANY  = 4;
    localparam int EXC_ANAN = 3;
    localparam int EXC_BNAN = 2;
    localparam int EXC_AINF = 1;
    localparam int EXC_BINF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [EXC_W-1:0] exc_vec(input logic [31:0] x, input logic [31:0] y);
        logic x_emax, y_emax, x_mz, y_mz;
        logic [EXC_W-1:0] v;
        x_emax = &x[30:23];
        y_emax = &y[30:23];
        x_mz   = (x[22:0] == 23'd0);
        y_mz   = (y[22:0] == 23'd0);
        v = '0;
        v[EXC_ANAN] = x_emax & ~x_mz;
        v[EXC_BNAN] = y_emax & ~y_mz;
        v[EXC_AINF] = x_emax & x_mz;
        v[EXC_BINF] = y_emax & y_mz;
        v[EXC_ANY]  = |v[EXC_ANAN:EXC_BINF];
        return v;
    endfunction

endpackage

// File: rtl/fpmult_pp_slice.sv
// Combinational 24 x SLICE_W unsigned partial product; a drop-in point for
// a DSP multiplier primitive.
module fpmult_pp_slice
    import fpmult_pkg::*;
#(
    parameter int SLICE_W = 6
) (
    input  logic [MANT_W-1:0]         a,
    input  logic [SLICE_W-1:0]        b,
    output logic [MANT_W+SLICE_W-1:0] p
);

    assign p = {{SLICE_W{1'b0}}, a} * {{MANT_W{1'b0}}, b};

endmodule

// File: rtl/fpmult_mant_seq.sv
// Iterative FP32 mantissa multiplier: one SLICE_W-wide slice of mb per cycle,
// LSB first, shift-accumulated into a 48-bit product.
module fpmult_mant_seq
    import fpmult_pkg::*;
#(
    parameter int SLICE_W    = 6,
    parameter int NUM_SLICES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sa,
    output logic              sb,
    output logic [EXP_W-1:0]  ea,
    output logic [EXP_W-1:0]  eb,
    output logic [PROD_W-1:0] mp,
    output logic [EXC_W-1:0]  input_exc,
    output logic              busy
);

    localparam int KW  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int SHW = $clog2(PROD_W) + 1;
    localparam int PPW = MANT_W + SLICE_W;

    if (SLICE_W * NUM_SLICES != MANT_W) begin : g_bad_param
        $error("SLICE_W*NUM_SLICES must equal 24");
    end

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [MANT_W-1:0]  ma_q, ma_d, mb_q, mb_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
    logic [EXC_W-1:0]   exc_q, exc_d;

    logic [SHW-1:0]     shamt;
    logic [SLICE_W-1:0] mb_slice;
    logic [PPW-1:0]     pp;

    assign shamt    = SHW'(k_q) * SHW'(SLICE_W);
    assign mb_slice = mb_q[shamt +: SLICE_W];

    fpmult_pp_slice #(.SLICE_W(SLICE_W)) u_pp (
        .a (ma_q),
        .b (mb_slice),
        .p (pp)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        exc_d   = exc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ITER;
                    k_d     = '0;
                    acc_d   = '0;
                    // hidden bit is zero for zero/denormal operands
                    ma_d    = {|a[30:23], a[22:0]};
                    mb_d    = {|b[30:23], b[22:0]};
                    sa_d    = a[31];
                    sb_d    = b[31];
                    ea_d    = a[30:23];
                    eb_d    = b[30:23];
                    exc_d   = exc_vec(a, b);
                end
            end
            ST_ITER: begin
                acc_d = acc_q + (PROD_W'(pp) << shamt);
                k_d   = k_q + KW'(1);
                if (k_q == KW'(NUM_SLICES - 1)) begin
                    state_d = ST_DONE;
                end
                if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            exc_q   <= exc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign mp        = acc_q;
    assign sa        = sa_q;
    assign sb        = sb_q;
    assign ea        = ea_q;
    assign eb        = eb_q;
    assign input_exc = exc_q;

endmodule
